// File: rtl/data_island_scheduler.sv
// HDMI data island sequencer: preamble/guard/packet-slot timing and packet arbitration.
// Define DATA_ISLAND_ACR_OVERRUN_EN to build the sticky ACR overrun flag and its event counter.
module data_island_scheduler #(
  parameter int MAX_PACKETS_PER_ISLAND = 18,
  parameter bit AUDIO_ENABLE = 1'b1
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       island_room,
  input  logic       frame_start,
  input  logic       acr_wrap,
  input  logic       sample_ready,
  output logic       sample_ack,
  output logic       preamble,
  output logic       guard,
  output logic       island,
  output logic [7:0] packet_type,
  output logic [4:0] packet_cycle,
  output logic       acr_overrun
);
  typedef enum logic [2:0] {IDLE, PRE, LGUARD, PKT, TGUARD} state_e;

  localparam logic [4:0] MaxPkt = 5'(MAX_PACKETS_PER_ISLAND);

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [4:0] pkt_cnt_q;
  logic       acr_q;
  logic       acr_pend_q;
  logic       avi_pend_q;
  logic       spd_pend_q;
  logic       aif_pend_q;

  logic       acr_edge;
  logic       smp_req;
  logic       any_req;
  logic       start;
  logic       cont;
  logic       arb;
  logic [7:0] grant_type;
  logic       g_acr;
  logic       g_smp;
  logic       g_avi;
  logic       g_spd;
  logic       g_aif;

  assign acr_edge = AUDIO_ENABLE && (acr_wrap != acr_q);
  assign smp_req  = AUDIO_ENABLE && sample_ready;
  assign any_req  = acr_pend_q | smp_req | avi_pend_q
                  | spd_pend_q | aif_pend_q;
  assign start    = island_room && any_req;
  assign cont     = (pkt_cnt_q < MaxPkt) && island_room && any_req;

  // Grant is decided the cycle before packet_cycle 0 of each slot.
  assign arb = ((state_q == LGUARD) && (cnt_q == 3'd1))
            || ((state_q == PKT) && (packet_cycle == 5'd31) && cont);

  always_comb begin
    grant_type = 8'h00;
    g_acr      = 1'b0;
    g_smp      = 1'b0;
    g_avi      = 1'b0;
    g_spd      = 1'b0;
    g_aif      = 1'b0;
    if (acr_pend_q) begin
      grant_type = 8'h01;
      g_acr      = 1'b1;
    end else if (smp_req) begin
      grant_type = 8'h02;
      g_smp      = 1'b1;
    end else if (avi_pend_q) begin
      grant_type = 8'h82;
      g_avi      = 1'b1;
    end else if (spd_pend_q) begin
      grant_type = 8'h83;
      g_spd      = 1'b1;
    end else if (aif_pend_q) begin
      grant_type = 8'h84;
      g_aif      = 1'b1;
    end
  end

  // A new request on the grant cycle wins over the clear.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acr_q      <= acr_wrap;
      acr_pend_q <= 1'b0;
      avi_pend_q <= 1'b0;
      spd_pend_q <= 1'b0;
      aif_pend_q <= 1'b0;
    end else begin
      acr_q <= acr_wrap;
      if (acr_edge)         acr_pend_q <= 1'b1;
      else if (arb && g_acr) acr_pend_q <= 1'b0;
      if (frame_start)      avi_pend_q <= 1'b1;
      else if (arb && g_avi) avi_pend_q <= 1'b0;
      if (frame_start)      spd_pend_q <= 1'b1;
      else if (arb && g_spd) spd_pend_q <= 1'b0;
      if (frame_start)      aif_pend_q <= 1'b1;
      else if (arb && g_aif) aif_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pkt_cnt_q    <= '0;
      preamble     <= 1'b0;
      guard        <= 1'b0;
      island       <= 1'b0;
      packet_type  <= '0;
      packet_cycle <= '0;
      sample_ack   <= 1'b0;
    end else begin
      sample_ack <= 1'b0;
      if (arb) begin
        packet_type  <= grant_type;
        packet_cycle <= '0;
        sample_ack   <= g_smp;
        pkt_cnt_q    <= pkt_cnt_q + 5'd1;
      end
      unique case (state_q)
        IDLE: begin
          pkt_cnt_q <= '0;
          if (start) begin
            state_q  <= PRE;
            cnt_q    <= '0;
            preamble <= 1'b1;
          end
        end
        PRE: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q  <= LGUARD;
            cnt_q    <= '0;
            preamble <= 1'b0;
            guard    <= 1'b1;
          end
        end
        LGUARD: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= PKT;
            guard   <= 1'b0;
            island  <= 1'b1;
          end
        end
        PKT: begin
          if (packet_cycle != 5'd31) begin
            packet_cycle <= packet_cycle + 5'd1;
          end else if (!cont) begin
            state_q      <= TGUARD;
            cnt_q        <= '0;
            island       <= 1'b0;
            guard        <= 1'b1;
            packet_type  <= '0;
            packet_cycle <= '0;
          end
        end
        TGUARD: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd1) begin
            guard     <= 1'b0;
            cnt_q     <= '0;
            pkt_cnt_q <= '0;
            if (start) begin
              state_q  <= PRE;
              preamble <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DATA_ISLAND_ACR_OVERRUN_EN
  logic        ovr_q;
  logic [15:0] ovr_cnt_q;
  logic        ovr_evt;

  assign ovr_evt = acr_edge && acr_pend_q && !(arb && g_acr);

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else if (ovr_evt) begin
      ovr_q <= 1'b1;
      if (ovr_cnt_q != 16'hffff) ovr_cnt_q <= ovr_cnt_q + 16'd1;
    end
  end

  assign acr_overrun = ovr_q;
`else
  assign acr_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_data_island_scheduler.sv
// Bench for data_island_scheduler: directed scenarios plus random traffic,
// every cycle compared against an island-position reference model.
module tb_data_island_scheduler;
  localparam int MAXP = 18;
  localparam bit AE = 1'b1;
`ifdef DATA_ISLAND_ACR_OVERRUN_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic       clk_pixel = 1'b0;
  logic       reset_n = 1'b0;
  logic       island_room = 1'b0;
  logic       frame_start = 1'b0;
  logic       acr_wrap = 1'b0;
  logic       sample_ready = 1'b0;
  logic       sample_ack;
  logic       preamble;
  logic       guard;
  logic       island;
  logic [7:0] packet_type;
  logic [4:0] packet_cycle;
  logic       acr_overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_pixel = ~clk_pixel;

  data_island_scheduler dut (
    .clk_pixel    (clk_pixel),
    .reset_n      (reset_n),
    .island_room  (island_room),
    .frame_start  (frame_start),
    .acr_wrap     (acr_wrap),
    .sample_ready (sample_ready),
    .sample_ack   (sample_ack),
    .preamble     (preamble),
    .guard        (guard),
    .island       (island),
    .packet_type  (packet_type),
    .packet_cycle (packet_cycle),
    .acr_overrun  (acr_overrun)
  );

  // Reference model: island described by its cycle position since the
  // first preamble cycle; m_end is where the trailing guard begins.
  int         m_pos;
  int         m_end;
  int         m_npk;
  bit         m_acr, m_avi, m_spd, m_aif, m_prev, m_ack, m_ovr;
  logic [7:0] m_type;

  int         st_pre, st_grd, st_isl, st_ack;
  logic [7:0] st_types[$];

  task automatic model_reset();
    m_pos = -1; m_end = -1; m_npk = 0;
    m_acr = 0; m_avi = 0; m_spd = 0; m_aif = 0;
    m_ack = 0; m_ovr = 0; m_type = 8'h00;
    m_prev = acr_wrap;
  endtask

  function automatic int m_pc();
    if (m_pos >= 10 && (m_end < 0 || m_pos < m_end)) return (m_pos - 10) % 32;
    return -1;
  endfunction

  task automatic model_step();
    bit sreq, edge_ev, any, arbit, gacr, gavi, gspd, gaif;
    int np, ne;
    if (!reset_n) begin
      model_reset();
      return;
    end
    sreq    = AE && sample_ready;
    edge_ev = AE && (acr_wrap != m_prev);
    any     = m_acr || sreq || m_avi || m_spd || m_aif;
    arbit = 0; gacr = 0; gavi = 0; gspd = 0; gaif = 0;
    m_ack = 0;
    ne = m_end;
    if (m_pos < 0 || (m_end >= 0 && m_pos == m_end + 1)) begin
      if (island_room && any) begin
        np = 0; ne = -1; m_npk = 0;
      end else begin
        np = -1;
      end
    end else begin
      np = m_pos + 1;
      if (m_pos == 9) arbit = 1;
      else if (m_pos >= 10 && m_end < 0 && (m_pos - 10) % 32 == 31) begin
        if (m_npk < MAXP && island_room && any) arbit = 1;
        else ne = m_pos + 1;
      end
    end
    if (arbit) begin
      m_npk++;
      if (m_acr)      begin m_type = 8'h01; gacr = 1; end
      else if (sreq)  begin m_type = 8'h02; m_ack = 1; end
      else if (m_avi) begin m_type = 8'h82; gavi = 1; end
      else if (m_spd) begin m_type = 8'h83; gspd = 1; end
      else if (m_aif) begin m_type = 8'h84; gaif = 1; end
      else m_type = 8'h00;
    end
    if (edge_ev && m_acr && !gacr) m_ovr = 1;
    m_acr = edge_ev ? 1'b1 : (gacr ? 1'b0 : m_acr);
    m_avi = frame_start ? 1'b1 : (gavi ? 1'b0 : m_avi);
    m_spd = frame_start ? 1'b1 : (gspd ? 1'b0 : m_spd);
    m_aif = frame_start ? 1'b1 : (gaif ? 1'b0 : m_aif);
    m_prev = acr_wrap;
    m_pos = np;
    m_end = ne;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit e_pre, e_g, e_isl;
    int pc;
    pc    = m_pc();
    e_isl = (pc >= 0);
    e_pre = (m_pos >= 0 && m_pos <= 7);
    e_g   = (m_pos == 8 || m_pos == 9)
         || (m_end >= 0 && (m_pos == m_end || m_pos == m_end + 1));
    chk("preamble", 32'(preamble), 32'(e_pre));
    chk("guard", 32'(guard), 32'(e_g));
    chk("island", 32'(island), 32'(e_isl));
    chk("packet_cycle", 32'(packet_cycle), e_isl ? 32'(pc) : 32'd0);
    chk("packet_type", 32'(packet_type), e_isl ? 32'(m_type) : 32'd0);
    chk("sample_ack", 32'(sample_ack), 32'(m_ack));
    chk("acr_overrun", 32'(acr_overrun), 32'(OVR_ON && m_ovr));
  endtask

  task automatic cyc();
    @(posedge clk_pixel);
    model_step();
    #1;
    check_all();
    if (preamble) st_pre++;
    if (guard) st_grd++;
    if (island) st_isl++;
    if (sample_ack) st_ack++;
    if (island && packet_cycle == 5'd0) st_types.push_back(packet_type);
  endtask

  task automatic clr();
    st_pre = 0; st_grd = 0; st_isl = 0; st_ack = 0;
    st_types.delete();
  endtask

  task automatic wait_pc(input int pc, input string tag);
    int k;
    k = 0;
    while (m_pc() != pc && k < 200) begin
      cyc();
      k++;
    end
    n_vec++;
    assert (m_pc() == pc) else begin
      n_err++;
      $error("FAIL %s observed=timeout expected=pc%0d", tag, pc);
    end
  endtask

  initial begin
    logic [7:0] exp5 [5];
    exp5 = '{8'h01, 8'h02, 8'h82, 8'h83, 8'h84};
    model_reset();
    clr();
    repeat (3) cyc();
    reset_n = 1'b1;

    // Single ACR request
    clr();
    island_room = 1'b1;
    acr_wrap = ~acr_wrap;
    repeat (60) cyc();
    chk("s1_pre_cycles", 32'(st_pre), 32'd8);
    chk("s1_guard_cycles", 32'(st_grd), 32'd4);
    chk("s1_island_cycles", 32'(st_isl), 32'd32);
    chk("s1_npkt", 32'(st_types.size()), 32'd1);
    chk("s1_type", 32'(st_types[0]), 32'h01);

    // All sources at once; sample buffer drains after its ack
    clr();
    acr_wrap = ~acr_wrap;
    frame_start = 1'b1;
    sample_ready = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (250) begin
      cyc();
      if (m_ack) sample_ready = 1'b0;
    end
    chk("s2_npkt", 32'(st_types.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("s2_order%0d", i), 32'(st_types[i]), 32'(exp5[i]));
    chk("s2_acks", 32'(st_ack), 32'd1);
    chk("s2_island_cycles", 32'(st_isl), 32'd160);

    // Packet limit: sample held high fills the island to 18 packets
    clr();
    acr_wrap = ~acr_wrap;
    frame_start = 1'b1;
    sample_ready = 1'b1;
    cyc();
    frame_start = 1'b0;
    repeat (800) begin
      cyc();
      if (m_pos >= 10 && m_end >= 0) sample_ready = 1'b0;
    end
    chk("s3_npkt", 32'(st_types.size()), 32'd21);
    chk("s3_first", 32'(st_types[0]), 32'h01);
    chk("s3_last_of_18", 32'(st_types[17]), 32'h02);
    chk("s3_next_island", 32'(st_types[18]), 32'h82);
    chk("s3_tail", 32'(st_types[20]), 32'h84);
    chk("s3_islands", 32'(st_pre), 32'd16);
    chk("s3_acks", 32'(st_ack), 32'd17);

    // Blanking ends mid-packet
    clr();
    acr_wrap = ~acr_wrap;
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    wait_pc(10, "s4_wait_pc10");
    island_room = 1'b0;
    repeat (40) cyc();
    chk("s4_npkt", 32'(st_types.size()), 32'd1);
    chk("s4_type", 32'(st_types[0]), 32'h01);
    chk("s4_guard_cycles", 32'(st_grd), 32'd4);
    island_room = 1'b1;
    repeat (150) cyc();
    chk("s4_npkt_after", 32'(st_types.size()), 32'd4);

    // Two ACR edges with no room
    clr();
    island_room = 1'b0;
    acr_wrap = ~acr_wrap;
    repeat (3) cyc();
    acr_wrap = ~acr_wrap;
    repeat (3) cyc();
    chk("s5_overrun", 32'(acr_overrun), 32'(OVR_ON));
    island_room = 1'b1;
    repeat (60) cyc();
    chk("s5_npkt", 32'(st_types.size()), 32'd1);
    chk("s5_type", 32'(st_types[0]), 32'h01);

    // Reset in the middle of a packet
    clr();
    acr_wrap = ~acr_wrap;
    wait_pc(5, "s6_wait_pc5");
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("s6_rst_island", 32'(island), 32'd0);
    chk("s6_rst_type", 32'(packet_type), 32'd0);
    chk("s6_rst_cycle", 32'(packet_cycle), 32'd0);
    chk("s6_rst_guard", 32'(guard), 32'd0);
    chk("s6_rst_pre", 32'(preamble), 32'd0);
    chk("s6_rst_ovr", 32'(acr_overrun), 32'd0);
    repeat (3) cyc();
    reset_n = 1'b1;
    clr();
    repeat (30) cyc();
    chk("s6_idle_after", 32'(st_pre), 32'd0);

    // Random traffic
    repeat (4000) begin
      island_room = ($urandom_range(0, 9) != 0);
      frame_start = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) acr_wrap = ~acr_wrap;
      if ($urandom_range(0, 49) == 0) sample_ready = ~sample_ready;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
